// File: rtl/lfsr_range_gen.sv
// Fibonacci XNOR LFSR with seed load, free-run stepping and a req/ack bounded-draw
// engine (rejection sampling into [LO,HI]). Optional period-wrap detect: LFSR_WRAP_DETECT_EN.
module lfsr_range_gen #(
  parameter int unsigned      WIDTH     = 5,
  parameter logic [WIDTH-1:0] TAPS      = 5'b10100,
  parameter int unsigned      LO        = 2,
  parameter int unsigned      HI        = 24,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             fallback,
  output logic             busy,
  output logic [WIDTH-1:0] state_out,
  output logic             wrap
);

  localparam int unsigned      TRY_W  = 8;
  localparam logic [WIDTH-1:0] LOCKUP = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LO_V   = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V   = WIDTH'(HI);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {IDLE, SEARCH} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_clean;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             advance;
  logic             ack_d, fallback_d, busy_d;
  logic [WIDTH-1:0] value_d;

  // Feedback and seed sanitising; all-ones would lock an XNOR LFSR.
  always_comb begin
    lfsr_next  = {lfsr_q[WIDTH-2:0], ~^(lfsr_q & TAPS)};
    seed_clean = (seed == LOCKUP) ? '0 : seed;
  end

  // Next-state and draw evaluation.
  always_comb begin
    fsm_d      = fsm_q;
    tries_d    = tries_q;
    lfsr_d     = lfsr_q;
    advance    = 1'b0;
    ack_d      = 1'b0;
    fallback_d = 1'b0;
    value_d    = value;
    busy_d     = 1'b0;

    case (fsm_q)
      IDLE: begin
        advance = step;
        // A req landing in the ack cycle belongs to the finished draw; drop it.
        if (req && !ack) begin
          fsm_d   = SEARCH;
          tries_d = '0;
        end
      end
      SEARCH: begin
        if (!seed_load) begin
          advance = 1'b1;
          if ((lfsr_q >= LO_V) && (lfsr_q <= HI_V)) begin
            value_d = lfsr_q;
            ack_d   = 1'b1;
            fsm_d   = IDLE;
          end else if (tries_q == LAST_TRY) begin
            value_d    = LO_V;
            ack_d      = 1'b1;
            fallback_d = 1'b1;
            fsm_d      = IDLE;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (seed_load) begin
      lfsr_d = seed_clean;
    end else if (advance) begin
      lfsr_d = lfsr_next;
    end

    busy_d = (fsm_d == SEARCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q    <= IDLE;
      lfsr_q   <= '0;
      tries_q  <= '0;
      ack      <= 1'b0;
      value    <= '0;
      fallback <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      ack      <= ack_d;
      value    <= value_d;
      fallback <= fallback_d;
      busy     <= busy_d;
    end
  end

  assign state_out = lfsr_q;

`ifdef LFSR_WRAP_DETECT_EN
  logic [WIDTH-1:0] start_q;
  logic [15:0]      period_q;

  // Start point and step count since the last reset or seed load.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q  <= '0;
      period_q <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (seed_load) begin
        start_q  <= seed_clean;
        period_q <= '0;
      end else if (advance) begin
        period_q <= period_q + 16'd1;
        wrap     <= (lfsr_next == start_q);
      end
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Self-checking bench for lfsr_range_gen: directed table, corner sequences and
// randomized draws against a transaction-level reference model.
module tb_lfsr_range_gen;

  localparam int unsigned W    = 5;
  localparam int unsigned LO   = 2;
  localparam int unsigned HI   = 24;
  localparam int unsigned MAXT = 8;
  localparam logic [4:0]  TAPS_M = 5'b10100;

  logic       clock = 1'b0;
  logic       reset, step, seed_load, req;
  logic [4:0] seed;
  logic       ack, fallback, busy, wrap;
  logic [4:0] value, state_out;
  logic       ack3, fallback3, busy3, wrap3;
  logic [4:0] value3, state3;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_state;
  logic [4:0] m_value;

  always #5 clock = ~clock;

  lfsr_range_gen dut (
    .clock(clock), .reset(reset), .step(step), .seed_load(seed_load), .seed(seed),
    .req(req), .ack(ack), .value(value), .fallback(fallback), .busy(busy),
    .state_out(state_out), .wrap(wrap)
  );

  lfsr_range_gen #(.WIDTH(5), .TAPS(5'b10100), .LO(30), .HI(30), .MAX_TRIES(4)) dut3 (
    .clock(clock), .reset(reset), .step(step), .seed_load(seed_load), .seed(seed),
    .req(req), .ack(ack3), .value(value3), .fallback(fallback3), .busy(busy3),
    .state_out(state3), .wrap(wrap3)
  );

  typedef struct {
    logic       step;
    logic       seed_load;
    logic [4:0] seed;
    logic [4:0] exp_state;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Next state: new bit is 1 when an even number of tapped bits are set.
  function automatic logic [4:0] nxt(input logic [4:0] s);
    logic fb;
    fb = (($countones(s & TAPS_M) % 2) == 0);
    return {s[3:0], fb};
  endfunction

  // Outcome of a draw starting from candidate s0 with default bounds.
  function automatic void model_draw(input logic [4:0] s0, output int k,
                                     output logic [4:0] v, output logic fb,
                                     output logic [4:0] s_end);
    logic [4:0] s;
    s = s0;
    k = MAXT;
    v = 5'(LO);
    fb = 1'b1;
    s_end = s0;
    for (int i = 0; i < MAXT; i++) begin
      if (s >= 5'(LO) && s <= 5'(HI)) begin
        k = i + 1;
        v = s;
        fb = 1'b0;
        s_end = nxt(s);
        return;
      end
      s = nxt(s);
    end
    s_end = s;
  endfunction

  task automatic do_reset;
    reset = 1'b1; step = 1'b0; req = 1'b0; seed_load = 1'b0; seed = '0;
    tick;
    tick;
    reset = 1'b0;
    m_state = '0;
    m_value = '0;
  endtask

  task automatic do_draw(input logic step_on_req);
    logic [4:0] s, v, s_end;
    logic       fb;
    int         k;
    s = m_state;
    req = 1'b1; step = step_on_req; seed_load = 1'b0;
    if (step_on_req) s = nxt(s);
    model_draw(s, k, v, fb, s_end);
    tick;
    for (int i = 0; i < k; i++) begin
      chk("draw_busy", busy, 1);
      chk("draw_no_early_ack", ack, 0);
      req = 1'($urandom);
      step = 1'($urandom);
      tick;
    end
    chk("draw_ack", ack, 1);
    chk("draw_value", value, v);
    chk("draw_fallback", fallback, fb);
    chk("draw_busy_clear", busy, 0);
    chk("draw_state", state_out, s_end);
    req = 1'b1; step = 1'b0;
    tick;
    chk("ackcycle_req_ignored", busy, 0);
    chk("ack_single_cycle", ack, 0);
    chk("value_held", value, v);
    req = 1'b0;
    m_state = s_end;
    m_value = v;
  endtask

  initial begin
    vec_t vt[10];
    logic [4:0] s;

    vt[0] = '{1'b1, 1'b0, 5'd0,  5'd1};
    vt[1] = '{1'b1, 1'b0, 5'd0,  5'd3};
    vt[2] = '{1'b1, 1'b0, 5'd0,  5'd7};
    vt[3] = '{1'b1, 1'b0, 5'd0,  5'd14};
    vt[4] = '{1'b1, 1'b0, 5'd0,  5'd28};
    vt[5] = '{1'b1, 1'b0, 5'd0,  5'd25};
    vt[6] = '{1'b0, 1'b1, 5'd31, 5'd0};
    vt[7] = '{1'b1, 1'b1, 5'd5,  5'd5};
    vt[8] = '{1'b0, 1'b0, 5'd0,  5'd5};
    vt[9] = '{1'b1, 1'b0, 5'd0,  5'd10};

    // Reset values
    do_reset;
    chk("rst_ack", ack, 0);
    chk("rst_value", value, 0);
    chk("rst_fallback", fallback, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_out, 0);
    chk("rst_wrap", wrap, 0);

    // Stepping and seed loads from the table
    foreach (vt[i]) begin
      step = vt[i].step; seed_load = vt[i].seed_load; seed = vt[i].seed;
      tick;
      chk("vec_state", state_out, vt[i].exp_state);
      chk("vec_busy", busy, 0);
      chk("vec_ack", ack, 0);
    end
    step = 1'b0; seed_load = 1'b0;

    // First draw from reset: 0,1 miss, 3 hits
    do_reset;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk("t2_busy0", busy, 1);
    chk("t2_state0", state_out, 0);
    tick;
    chk("t2_busy1", busy, 1);
    chk("t2_state1", state_out, 1);
    tick;
    chk("t2_busy2", busy, 1);
    chk("t2_ack_early", ack, 0);
    tick;
    chk("t2_ack", ack, 1);
    chk("t2_value", value, 3);
    chk("t2_fallback", fallback, 0);
    chk("t2_busy_clear", busy, 0);
    chk("t2_state", state_out, 7);
    tick;
    chk("t2_ack_pulse", ack, 0);
    chk("t2_value_held", value, 3);

    // Fallback on the LO=HI=30, MAX_TRIES=4 instance; req held throughout
    do_reset;
    req = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("t3_busy", busy3, 1);
      chk("t3_no_ack", ack3, 0);
      tick;
    end
    chk("t3_ack", ack3, 1);
    chk("t3_value", value3, 30);
    chk("t3_fallback", fallback3, 1);
    chk("t3_state", state3, 14);
    tick;
    chk("t3_req_ignored", busy3, 0);
    chk("t3_ack_pulse", ack3, 0);
    chk("t3_fallback_pulse", fallback3, 0);
    req = 1'b0;

    // Seed load mid-search: loaded value judged next edge, tries kept
    do_reset;
    req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    chk("t4_state_pre", state_out, 1);
    seed_load = 1'b1; seed = 5'd0;
    tick;
    seed_load = 1'b0;
    chk("t4_loaded", state_out, 0);
    chk("t4_busy", busy, 1);
    chk("t4_no_ack", ack, 0);
    chk("t4_busy3", busy3, 1);
    tick;
    tick;
    chk("t4_busy_late", busy, 1);
    chk("t4_busy3_late", busy3, 1);
    chk("t4_no_ack3", ack3, 0);
    tick;
    chk("t4_ack", ack, 1);
    chk("t4_value", value, 3);
    chk("t4_ack3", ack3, 1);
    chk("t4_fallback3", fallback3, 1);
    chk("t4_value3", value3, 30);
    chk("t4_state3", state3, 7);

    // Reset mid-search aborts the draw
    do_reset;
    req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_ack", ack, 0);
    chk("t5_state", state_out, 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t5_no_late_ack", ack, 0);
    end

    // Period wrap with step held
    do_reset;
    s = '0;
    step = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      tick;
      s = nxt(s);
      chk("t6_state", state_out, s);
      chk("t6_state3", state3, s);
`ifdef LFSR_WRAP_DETECT_EN
      chk("t6_wrap", wrap, (i % 31) == 0);
      chk("t6_wrap3", wrap3, (i % 31) == 0);
`else
      chk("t6_wrap", wrap, 0);
      chk("t6_wrap3", wrap3, 0);
`endif
    end
    step = 1'b0;

    // Bound edges: candidates just inside and outside [LO,HI]
    do_reset;
    foreach (vt[i]) begin
      if (i < 4) begin
        logic [4:0] b[4];
        b[0] = 5'd1; b[1] = 5'd2; b[2] = 5'd24; b[3] = 5'd25;
        seed_load = 1'b1; seed = b[i];
        tick;
        seed_load = 1'b0;
        m_state = b[i];
        do_draw(1'b0);
      end
    end

    // Randomized operations against the model
    do_reset;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
            step = 1'($urandom); req = 1'b0; seed_load = 1'b0;
            tick;
            if (step) m_state = nxt(m_state);
            chk("rnd_step_state", state_out, m_state);
            chk("rnd_step_busy", busy, 0);
            chk("rnd_value_held", value, m_value);
          end
        end
        1: begin
          seed = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
          seed_load = 1'b1; step = 1'($urandom); req = 1'b0;
          tick;
          seed_load = 1'b0;
          m_state = (seed == 5'd31) ? 5'd0 : seed;
          chk("rnd_seed_state", state_out, m_state);
        end
        default: do_draw(1'($urandom));
      endcase
    end
    step = 1'b0; req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
